pipelined_adder: RTL and testbench
==================================

Name: pipelined_adder

Overview:
- Parametrised, pipelined multi-bit adder built from the team's ripple-carry style.
- Adds two WIDTH-bit operands plus carry-in in STAGES chunks of WIDTH/STAGES bits, one chunk per pipeline stage.
- Per-stage valid/ready flow control with bubble collapse.
- Serves as the arithmetic primitive for wide accumulators and datapaths that need full throughput at high clock rates.

Parameters:
- WIDTH, 16, operand and sum width in bits.
- STAGES, 4, number of pipeline stages. Must divide WIDTH exactly; elaboration error otherwise. STAGES=1 is legal.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous, active-low reset
- in_valid  input  1  operands on a/b/cin are valid
- in_ready  output  1  block accepts operands this cycle
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- cin  input  1  carry-in
- out_valid  output  1  s/cout hold a completed result
- out_ready  input  1  downstream accepts result this cycle
- s  output  WIDTH  sum, a+b+cin mod 2^WIDTH
- cout  output  1  carry-out of bit WIDTH-1

Behaviour:
- Reset: one clock, clk; reset rst_n is asynchronous and active-low. Asserting rst_n=0 immediately clears every stage valid bit, so out_valid=0. Data registers are don't-care; s=0 and cout=0 are still required at reset.
- Transactions, in and out:
  - Input transfer occurs when in_valid && in_ready on a rising clk edge.
  - Output transfer occurs when out_valid && out_ready.
- Chunking: CHUNK=WIDTH/STAGES.
  - Stage k (0..STAGES-1) computes sum bits [k*CHUNK +: CHUNK] from the operand chunks and the carry registered by stage k-1. Stage 0 uses cin.
  - Each stage registers: valid bit, carry out of its chunk, sum bits produced so far, and the still-unconsumed upper operand chunks.
- Flow control, per stage k:
  - ready_k = !valid_k || ready_{k+1}, with ready_STAGES = out_ready.
  - in_ready = ready_0 (combinational from out_ready; no register in that path is required).
  - A stage loads when its upstream is valid and ready_k is 1.
  - A stage clears valid when it hands data on and receives nothing.
- Latency: exactly STAGES cycles from input transfer to out_valid, when no stall occurs.
- Throughput: one result per cycle with out_ready held high.
- Stall: while out_valid=1 and out_ready=0, s and cout hold stable and out_valid stays 1.
  - Upstream bubbles collapse, so empty stages continue to fill.
  - in_ready goes low only when all STAGES stages are valid and out_ready=0.
- Ordering: results leave in acceptance order. No drop and no duplication.
- Arithmetic: no signedness. cout is the true carry; overflow interpretation is the consumer's job.
- Simultaneous events: a full pipeline with out_ready=1 and in_valid=1 accepts a new operand in the same cycle the oldest result leaves.
- Reset mid-operation: all in-flight transactions are discarded. No result from before reset may appear after rst_n deasserts.
- in_valid with in_ready=0: inputs are ignored. The source must hold them; the block does not check this.

Decomposition:
- Package adder_pkg holds the function for chunk width (WIDTH/STAGES) and the elaboration check that STAGES divides WIDTH.
- Sub-module adder_stage has parameters CHUNK and index k:
  - a registered CHUNK-bit ripple adder, with local valid/ready;
  - pass-through registers for upper operand chunks and lower sum bits.
- pipelined_adder instantiates STAGES adder_stage via generate and ties the ready chain.

Test Plan (WIDTH=16, STAGES=4 unless stated):
1. Carry ripples across all chunks: a=16'hFFFF, b=16'h0001, cin=0, out_ready=1 -> after 4 cycles out_valid=1, s=16'h0000, cout=1, for one cycle.
2. Back-to-back stream: 8 consecutive pairs (i, 16'h1000+i, cin=i[0]) with out_ready=1 -> results on 8 consecutive cycles starting at cycle 4, in order, each matching the reference sum; in_ready stays 1.
3. Backpressure: stream of 6 pairs with out_ready=0 from cycle 3 -> first result held stable; in_ready=0 once 4 stages are valid; after out_ready=1, all 6 results emerge in order with no loss.
4. Bubbles: inputs on cycles 0, 2, 5 only -> outputs on cycles 4, 6, 9; out_valid=0 on all other cycles.
5. Reset mid-operation: 3 transactions in flight, pull rst_n low asynchronously between edges -> out_valid=0 immediately; after release, no stale result appears within 10 cycles.
6. STAGES=1, WIDTH=8: a=8'h80, b=8'h80, cin=1 -> next cycle s=8'h01, cout=1; in_ready follows out_ready when full.

Source files
------------

// File: rtl/adder_pkg.sv
// adder_pkg: chunk sizing and legality helpers shared by the pipelined adder
package adder_pkg;
    function automatic int chunk_width(input int width, input int stages);
        return width / stages;
    endfunction
    function automatic bit stages_divide(input int width, input int stages);
        return stages > 0 && width % stages == 0;
    endfunction
endpackage

// File: rtl/pipelined_adder_if.sv
// pipelined_adder_if: operand/result valid-ready bundle; master drives operands and out_ready, slave returns sum
interface pipelined_adder_if #(parameter int WIDTH = 16);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] s;
    logic             cout;
    modport master (output in_valid, a, b, cin, out_ready, input in_ready, out_valid, s, cout);
    modport slave (input in_valid, a, b, cin, out_ready, output in_ready, out_valid, s, cout);
endinterface

// File: rtl/adder_stage.sv
// adder_stage: one registered CHUNK-bit ripple slice; ready comes from the parent's chain, up_* in, dn_* out
module adder_stage #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4,
    parameter int K     = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ready,
    input  logic             up_valid,
    input  logic [WIDTH-1:0] up_a,
    input  logic [WIDTH-1:0] up_b,
    input  logic [WIDTH-1:0] up_sum,
    input  logic             up_carry,
    output logic             dn_valid,
    output logic [WIDTH-1:0] dn_a,
    output logic [WIDTH-1:0] dn_b,
    output logic [WIDTH-1:0] dn_sum,
    output logic             dn_carry
);
    logic             valid_q, valid_d, carry_q, carry_d, carry_n, load;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, sum_q, sum_d, sum_n;
    logic [CHUNK-1:0] chunk_n;
    always_comb begin
        {carry_n, chunk_n} = {1'b0, up_a[K*CHUNK +: CHUNK]} + {1'b0, up_b[K*CHUNK +: CHUNK]} + {{CHUNK{1'b0}}, up_carry};
        sum_n = up_sum;
        sum_n[K*CHUNK +: CHUNK] = chunk_n;
        load = up_valid && ready;
        valid_d = ready ? up_valid : valid_q;
        a_d = load ? up_a : a_q;
        b_d = load ? up_b : b_q;
        sum_d = load ? sum_n : sum_q;
        carry_d = load ? carry_n : carry_q;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            carry_q <= 1'b0;
            a_q <= '0;
            b_q <= '0;
            sum_q <= '0;
        end else begin
            valid_q <= valid_d;
            carry_q <= carry_d;
            a_q <= a_d;
            b_q <= b_d;
            sum_q <= sum_d;
        end
    end
    assign dn_valid = valid_q;
    assign dn_a = a_q;
    assign dn_b = b_q;
    assign dn_sum = sum_q;
    assign dn_carry = carry_q;
endmodule

// File: rtl/pipelined_adder.sv
// pipelined_adder: STAGES-deep chunked adder, s/cout = a+b+cin; clk, async rst_n, io carries the valid/ready bus
module pipelined_adder import adder_pkg::*; #(
    parameter int WIDTH  = 16,
    parameter int STAGES = 4
) (
    input logic clk,
    input logic rst_n,
    pipelined_adder_if.slave io
);
    localparam int CHUNK = chunk_width(WIDTH, STAGES);
    if (!stages_divide(WIDTH, STAGES)) begin : g_bad_stages
        $error("pipelined_adder: STAGES must divide WIDTH");
    end
    logic [STAGES:0]            vld, cy, rdy;
    logic [STAGES:0][WIDTH-1:0] a_w, b_w, sum_w;
    logic                       unused_operands;
    // Walk the chain from the output back so each stage sees whether the one ahead frees up this cycle.
    always_comb begin
        rdy[STAGES] = io.out_ready;
        for (int i = STAGES - 1; i >= 0; i--) rdy[i] = !vld[i+1] || rdy[i+1];
    end
    assign vld[0] = io.in_valid;
    assign a_w[0] = io.a;
    assign b_w[0] = io.b;
    assign sum_w[0] = '0;
    assign cy[0] = io.cin;
    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        adder_stage #(.WIDTH(WIDTH), .CHUNK(CHUNK), .K(k)) u_stage (
            .clk(clk),
            .rst_n(rst_n),
            .ready(rdy[k]),
            .up_valid(vld[k]),
            .up_a(a_w[k]),
            .up_b(b_w[k]),
            .up_sum(sum_w[k]),
            .up_carry(cy[k]),
            .dn_valid(vld[k+1]),
            .dn_a(a_w[k+1]),
            .dn_b(b_w[k+1]),
            .dn_sum(sum_w[k+1]),
            .dn_carry(cy[k+1])
        );
    end
    // Operands leaving the last stage are fully consumed.
    assign unused_operands = ^{a_w[STAGES], b_w[STAGES]};
    assign io.in_ready = rdy[0];
    assign io.out_valid = vld[STAGES];
    assign io.s = sum_w[STAGES];
    assign io.cout = cy[STAGES];
endmodule

// File: tb/tb_pipelined_adder.sv
// tb_pipelined_adder: ideal elastic-FIFO reference model plus directed literals for 16/4 and 8/1 adders
module tb_pipelined_adder;
    typedef struct {
        logic [16:0] e;
        int          acc;
    } item_t;
    logic  clk = 1'b0;
    logic  rst_n;
    int    cyc = 0;
    int    n_cmp = 0;
    int    n_bad = 0;
    int    dlv [2] = '{0, 0};
    int    last_l [2] = '{-100, -100};
    item_t q0[$];
    item_t q1[$];
    logic  took0 = 1'b0;
    logic  took1 = 1'b0;
    int    d0, j;

    pipelined_adder_if #(.WIDTH(16)) bus ();
    pipelined_adder_if #(.WIDTH(8)) bus2 ();
    pipelined_adder #(.WIDTH(16), .STAGES(4)) dut (.clk(clk), .rst_n(rst_n), .io(bus));
    pipelined_adder #(.WIDTH(8), .STAGES(1)) dut1 (.clk(clk), .rst_n(rst_n), .io(bus2));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", nm, cyc, got, exp);
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.in_valid = 1'b0;
        bus.a = '0;
        bus.b = '0;
        bus.cin = 1'b0;
        bus.out_ready = 1'b1;
        bus2.in_valid = 1'b0;
        bus2.a = '0;
        bus2.b = '0;
        bus2.cin = 1'b0;
        bus2.out_ready = 1'b1;
    endtask

    // Reference: the pipeline behaves as an ideal FIFO of depth STAGES where an item
    // may appear no earlier than STAGES cycles after acceptance and one cycle after its predecessor left.
    always @(negedge clk) begin
        logic        ov, ir, iv, orr, ev;
        logic [16:0] got, nw;
        int          st, n;
        item_t       f;
        for (int d = 0; d < 2; d++) begin
            if (d == 1) begin
                ov = bus2.out_valid; ir = bus2.in_ready; iv = bus2.in_valid; orr = bus2.out_ready;
                got = {8'b0, bus2.cout, bus2.s};
                nw = 17'(bus2.a) + 17'(bus2.b) + 17'(bus2.cin);
                st = 1;
                n = q1.size();
            end else begin
                ov = bus.out_valid; ir = bus.in_ready; iv = bus.in_valid; orr = bus.out_ready;
                got = {bus.cout, bus.s};
                nw = 17'(bus.a) + 17'(bus.b) + 17'(bus.cin);
                st = 4;
                n = q0.size();
            end
            if (!rst_n) begin
                chk(d == 1 ? "rst_out_valid_8" : "rst_out_valid_16", 32'(ov), 0);
                chk(d == 1 ? "rst_sum_8" : "rst_sum_16", 32'(got), 0);
                if (d == 1) q1.delete(); else q0.delete();
                last_l[d] = -100;
            end else begin
                f = '{17'd0, 0};
                if (n > 0) f = (d == 1) ? q1[0] : q0[0];
                ev = n > 0 && cyc >= f.acc + st && cyc >= last_l[d] + 1;
                chk(d == 1 ? "out_valid_8" : "out_valid_16", 32'(ov), 32'(ev));
                chk(d == 1 ? "in_ready_8" : "in_ready_16", 32'(ir), 32'(n < st || orr));
                if (ev) chk(d == 1 ? "result_8" : "result_16", 32'(got), 32'(f.e));
                if (ev && orr) begin
                    if (d == 1) void'(q1.pop_front()); else void'(q0.pop_front());
                    last_l[d] = cyc;
                    dlv[d]++;
                end
                if (iv && (n < st || orr)) begin
                    if (d == 1) q1.push_back('{nw, cyc}); else q0.push_back('{nw, cyc});
                end
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        idle();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        // carry ripples through every chunk
        nxt();
        bus.in_valid = 1'b1; bus.a = 16'hFFFF; bus.b = 16'h0001; bus.cin = 1'b0;
        for (int c = 1; c <= 5; c++) begin
            nxt();
            bus.in_valid = 1'b0;
            @(negedge clk);
            if (c == 4) begin
                chk("t1_valid", 32'(bus.out_valid), 1);
                chk("t1_sum", 32'(bus.s), 32'h0000);
                chk("t1_cout", 32'(bus.cout), 1);
            end else chk("t1_idle_valid", 32'(bus.out_valid), 0);
        end
        // back-to-back stream
        d0 = dlv[0];
        for (int c = 0; c < 14; c++) begin
            nxt();
            bus.in_valid = c < 8;
            bus.a = 16'(c);
            bus.b = 16'h1000 + 16'(c);
            bus.cin = c[0];
            @(negedge clk);
            if (c == 4) chk("t2_first", 32'({bus.cout, bus.s}), 32'h01000);
        end
        chk("t2_count", 32'(dlv[0] - d0), 8);
        // backpressure from cycle 3 until cycle 12
        d0 = dlv[0];
        j = 0;
        for (int c = 0; c < 30; c++) begin
            nxt();
            bus.out_ready = c < 3 || c >= 12;
            bus.in_valid = j < 6;
            bus.a = j == 0 ? 16'h1234 : 16'(j * 9001);
            bus.b = j == 0 ? 16'h4321 : 16'(j * 777);
            bus.cin = j == 0 ? 1'b1 : 1'(j);
            @(negedge clk);
            if (bus.in_valid && bus.in_ready) j++;
            if (c == 6) begin
                chk("t3_in_ready_full", 32'(bus.in_ready), 0);
                chk("t3_held_valid", 32'(bus.out_valid), 1);
                chk("t3_held_sum", 32'({bus.cout, bus.s}), 32'h05556);
            end
        end
        chk("t3_count", 32'(dlv[0] - d0), 6);
        // bubbles
        for (int c = 0; c < 12; c++) begin
            nxt();
            bus.out_ready = 1'b1;
            bus.in_valid = c == 0 || c == 2 || c == 5;
            bus.a = 16'($urandom);
            bus.b = 16'($urandom);
            bus.cin = 1'($urandom);
            @(negedge clk);
            chk("t4_valid_pattern", 32'(bus.out_valid), 32'(c == 4 || c == 6 || c == 9));
        end
        // asynchronous reset with results in flight
        for (int c = 0; c < 5; c++) begin
            nxt();
            bus.out_ready = 1'b0;
            bus.in_valid = c < 3;
            bus.a = 16'($urandom);
            bus.b = 16'($urandom);
        end
        #2;
        chk("t5_valid_before_reset", 32'(bus.out_valid), 1);
        rst_n = 1'b0;
        #1;
        chk("t5_async_clear", 32'(bus.out_valid), 0);
        chk("t5_async_sum", 32'({bus.cout, bus.s}), 0);
        idle();
        @(posedge clk);
        #3 rst_n = 1'b1;
        for (int c = 0; c < 10; c++) begin
            nxt();
            @(negedge clk);
            chk("t5_no_stale", 32'(bus.out_valid), 0);
        end
        // single-stage 8-bit instance
        nxt();
        bus2.in_valid = 1'b1; bus2.a = 8'h80; bus2.b = 8'h80; bus2.cin = 1'b1; bus2.out_ready = 1'b1;
        nxt();
        bus2.in_valid = 1'b0;
        @(negedge clk);
        chk("t6_valid", 32'(bus2.out_valid), 1);
        chk("t6_sum", 32'({bus2.cout, bus2.s}), 32'h101);
        nxt();
        bus2.in_valid = 1'b1; bus2.a = 8'h10; bus2.b = 8'h20; bus2.cin = 1'b0; bus2.out_ready = 1'b0;
        @(negedge clk);
        chk("t6_empty_ready", 32'(bus2.in_ready), 1);
        nxt();
        bus2.a = 8'h33; bus2.b = 8'h44;
        @(negedge clk);
        chk("t6_full_stalled", 32'(bus2.in_ready), 0);
        chk("t6_held_sum", 32'({bus2.cout, bus2.s}), 32'h030);
        nxt();
        bus2.out_ready = 1'b1;
        @(negedge clk);
        chk("t6_ready_follows", 32'(bus2.in_ready), 1);
        nxt();
        bus2.in_valid = 1'b0;
        @(negedge clk);
        chk("t6_next_sum", 32'({bus2.cout, bus2.s}), 32'h077);
        // randomized traffic on both instances
        for (int c = 0; c < 400; c++) begin
            nxt();
            if (!bus.in_valid || took0) begin
                bus.in_valid = $urandom_range(0, 3) != 0;
                bus.a = 16'($urandom);
                bus.b = 16'($urandom);
                bus.cin = 1'($urandom);
            end
            if (!bus2.in_valid || took1) begin
                bus2.in_valid = $urandom_range(0, 3) != 0;
                bus2.a = 8'($urandom);
                bus2.b = 8'($urandom);
                bus2.cin = 1'($urandom);
            end
            bus.out_ready = $urandom_range(0, 3) != 0;
            bus2.out_ready = $urandom_range(0, 3) != 0;
            @(negedge clk);
            took0 = bus.in_valid && bus.in_ready;
            took1 = bus2.in_valid && bus2.in_ready;
        end
        nxt();
        idle();
        repeat (10) nxt();
        @(negedge clk);
        chk("drain_16", 32'(q0.size()), 0);
        chk("drain_8", 32'(q1.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
